// File: rtl/gmii_pkg.sv
// Shared GMII constants, monitor state encoding and small helpers
// used by the loopback PHY model.
package gmii_pkg;

    localparam logic [7:0] GMII_PREAMBLE    = 8'h55;
    localparam logic [7:0] GMII_SFD         = 8'hD5;
    localparam logic [7:0] GMII_CARRIER_EXT = 8'h0F;

    typedef enum logic [1:0] {
        MON_IDLE     = 2'd0,
        MON_PREAMBLE = 2'd1,
        MON_DATA     = 2'd2,
        MON_BAD      = 2'd3
    } mon_state_e;

    // One transmit-side GMII beat as carried through the loopback pipeline.
    typedef struct packed {
        logic [7:0] data;
        logic       en;
        logic       er;
    } gmii_beat_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/gmii_frame_monitor.sv
// Transmit frame monitor: checks preamble/SFD, frame length and tx_er,
// and keeps saturating good/bad frame statistics.
module gmii_frame_monitor
    import gmii_pkg::*;
#(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  txd,
    input  logic        tx_en,
    input  logic        tx_er,
    input  logic        clear_stats,
    output logic [15:0] frame_count,
    output logic [15:0] err_count,
    output logic [15:0] last_len,
    output logic        preamble_err
);

    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);

    mon_state_e  state_q, state_d;
    logic [2:0]  pre_cnt_q, pre_cnt_d, cnt_in;
    logic [15:0] len_q, len_d;
    logic        er_q, er_d;
    logic        prev_en_q;
    logic        pre_byte, pre_bad, frame_end, frame_good;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        len_d     = len_q;
        er_d      = er_q;
        cnt_in    = pre_cnt_q;
        pre_byte  = 1'b0;
        pre_bad   = 1'b0;
        frame_end = 1'b0;

        case (state_q)
            // prev_en_q resets high, so a frame already running at reset release is skipped.
            MON_IDLE: begin
                if (tx_en && !prev_en_q) begin
                    pre_byte = 1'b1;
                    cnt_in   = '0;
                    len_d    = '0;
                    er_d     = 1'b0;
                end
            end
            MON_PREAMBLE: pre_byte = tx_en;
            MON_DATA:     if (tx_en) len_d = sat_inc(len_q);
            default: ;
        endcase

        if (tx_en && tx_er)
            er_d = 1'b1;

        if (pre_byte) begin
            if (txd == GMII_PREAMBLE && cnt_in != 3'd7) begin
                state_d   = MON_PREAMBLE;
                pre_cnt_d = cnt_in + 3'd1;
            end else if (txd == GMII_SFD && cnt_in != 3'd0) begin
                state_d = MON_DATA;
            end else begin
                state_d = MON_BAD;
                pre_bad = 1'b1;
            end
        end

        if (state_q != MON_IDLE && !tx_en) begin
            frame_end = 1'b1;
            state_d   = MON_IDLE;
        end
    end

    assign frame_good = (state_q == MON_DATA) && !er_q &&
                        (len_q >= MIN_LEN) && (len_q <= MAX_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= MON_IDLE;
            pre_cnt_q    <= '0;
            len_q        <= '0;
            er_q         <= 1'b0;
            prev_en_q    <= 1'b1;
            frame_count  <= '0;
            err_count    <= '0;
            last_len     <= '0;
            preamble_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            len_q     <= len_d;
            er_q      <= er_d;
            prev_en_q <= tx_en;
            if (clear_stats) begin
                frame_count  <= '0;
                err_count    <= '0;
                last_len     <= '0;
                preamble_err <= 1'b0;
            end else begin
                if (frame_end) begin
                    last_len <= (state_q == MON_DATA) ? len_q : '0;
                    if (frame_good) frame_count <= sat_inc(frame_count);
                    else            err_count   <= sat_inc(err_count);
                end
                if (pre_bad)
                    preamble_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gmii_phy.sv
// GMII loopback PHY model: delays the MAC transmit stream onto the receive
// side through a fixed-depth pipeline and monitors transmitted frames.
module gmii_phy
    import gmii_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic        phy_gtx_clk,
    input  logic        phy_rst_n,
    input  logic [7:0]  phy_txd,
    input  logic        phy_tx_en,
    input  logic        phy_tx_er,
    output logic        phy_tx_clk,
    output logic        phy_rx_clk,
    output logic [7:0]  phy_rxd,
    output logic        phy_rx_dv,
    output logic        phy_rx_er,
    input  logic        loopback_en,
    input  logic        clear_stats,
    output logic [15:0] frame_count,
    output logic [15:0] err_count,
    output logic [15:0] last_len,
    output logic        preamble_err
);

    gmii_beat_t pipe_q [LATENCY];
    gmii_beat_t last_beat;
    logic       gate_q;
    logic       in_flight;
    logic [7:0] rxd_d;
    logic       rx_dv_d, rx_er_d;

    assign phy_tx_clk = phy_gtx_clk;
    assign phy_rx_clk = phy_gtx_clk;
    assign last_beat  = pipe_q[LATENCY-1];

    always_comb begin
        in_flight = phy_tx_en;
        for (int i = 0; i < LATENCY; i++)
            in_flight = in_flight | pipe_q[i].en;
    end

    // Carrier extend / false carrier (en=0, er=1) is passed through with its data byte.
    always_comb begin
        rxd_d   = 8'h00;
        rx_dv_d = 1'b0;
        rx_er_d = 1'b0;
        if (gate_q && (last_beat.en || last_beat.er)) begin
            rxd_d   = last_beat.data;
            rx_dv_d = last_beat.en;
            rx_er_d = last_beat.er;
        end
    end

    always_ff @(posedge phy_gtx_clk or negedge phy_rst_n) begin
        if (!phy_rst_n) begin
            // NOTE: the delay line is a handful of flops, so it is reset like any other state.
            for (int i = 0; i < LATENCY; i++)
                pipe_q[i] <= '0;
            gate_q    <= 1'b0;
            phy_rxd   <= 8'h00;
            phy_rx_dv <= 1'b0;
            phy_rx_er <= 1'b0;
        end else begin
            pipe_q[0] <= '{data: phy_txd, en: phy_tx_en, er: phy_tx_er};
            for (int i = 1; i < LATENCY; i++)
                pipe_q[i] <= pipe_q[i-1];
            // The gate only moves between frames so rx never sees a truncated or spliced frame.
            if (!in_flight)
                gate_q <= loopback_en;
            phy_rxd   <= rxd_d;
            phy_rx_dv <= rx_dv_d;
            phy_rx_er <= rx_er_d;
        end
    end

    gmii_frame_monitor #(
        .MIN_FRAME (MIN_FRAME),
        .MAX_FRAME (MAX_FRAME)
    ) u_mon (
        .clk          (phy_gtx_clk),
        .rst_n        (phy_rst_n),
        .txd          (phy_txd),
        .tx_en        (phy_tx_en),
        .tx_er        (phy_tx_er),
        .clear_stats  (clear_stats),
        .frame_count  (frame_count),
        .err_count    (err_count),
        .last_len     (last_len),
        .preamble_err (preamble_err)
    );

endmodule

// File: tb/tb_gmii_phy.sv
// Self-checking bench for gmii_phy: rx stream scoreboard plus a frame
// statistics model driven alongside the stimulus.
module tb_gmii_phy;
    import gmii_pkg::*;

    localparam int LAT = 4;
    localparam int MIN = 64;
    localparam int MAX = 1518;

    logic        clk, rst_n;
    logic [7:0]  txd;
    logic        tx_en, tx_er;
    logic        tx_clk, rx_clk;
    logic [7:0]  rxd;
    logic        rx_dv, rx_er;
    logic        loopback_en, clear_stats;
    logic [15:0] frame_count, err_count, last_len;
    logic        preamble_err;

    gmii_phy #(.LATENCY(LAT), .MIN_FRAME(MIN), .MAX_FRAME(MAX)) dut (
        .phy_gtx_clk  (clk),
        .phy_rst_n    (rst_n),
        .phy_txd      (txd),
        .phy_tx_en    (tx_en),
        .phy_tx_er    (tx_er),
        .phy_tx_clk   (tx_clk),
        .phy_rx_clk   (rx_clk),
        .phy_rxd      (rxd),
        .phy_rx_dv    (rx_dv),
        .phy_rx_er    (rx_er),
        .loopback_en  (loopback_en),
        .clear_stats  (clear_stats),
        .frame_count  (frame_count),
        .err_count    (err_count),
        .last_len     (last_len),
        .preamble_err (preamble_err)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [9:0]  sb [$];
    logic        lb_en = 1'b0;
    logic        clr   = 1'b0;
    logic        gate_model = 1'b0;
    int          idle_run = LAT;
    logic [15:0] exp_frames = '0, exp_err = '0, exp_len = '0;
    logic        exp_pre = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected rx for one beat as seen by the MAC, given the loopback gate.
    function automatic logic [9:0] rx_model(input logic g, input logic [7:0] d,
                                            input logic en, input logic er);
        if (g && en) return {d, 1'b1, er};
        if (g && er) return {d, 1'b0, 1'b1};
        return 10'h000;
    endfunction

    task automatic tick(input logic [7:0] d, input logic en, input logic er);
        @(posedge clk);
        #1;
        txd         = d;
        tx_en       = en;
        tx_er       = er;
        loopback_en = lb_en;
        clear_stats = clr;
        sb.push_back(rx_model(gate_model, d, en, er));
        idle_run = en ? 0 : idle_run + 1;
        if (idle_run >= LAT + 1)
            gate_model = lb_en;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int npre, input logic [7:0] sfd, input int len,
                              input int er_at, input int drop_at);
        logic valid, good;
        for (int i = 0; i < npre; i++) tick(8'h55, 1'b1, 1'b0);
        tick(sfd, 1'b1, 1'b0);
        for (int i = 0; i < len; i++) begin
            if (i == drop_at) lb_en = 1'b0;
            tick(8'($urandom), 1'b1, 1'(i == er_at));
        end
        valid = (npre >= 1) && (npre <= 7) && (sfd == 8'hD5);
        good  = valid && !(er_at >= 0 && er_at < len) && (len >= MIN) && (len <= MAX);
        exp_len = valid ? 16'(len) : 16'h0000;
        if (!valid) exp_pre = 1'b1;
        if (good) begin
            if (exp_frames != 16'hFFFF) exp_frames++;
        end else begin
            if (exp_err != 16'hFFFF) exp_err++;
        end
    endtask

    task automatic check_stats(input string tag);
        check({tag, ".frame_count"}, 32'(frame_count), 32'(exp_frames));
        check({tag, ".err_count"},   32'(err_count),   32'(exp_err));
        check({tag, ".last_len"},    32'(last_len),    32'(exp_len));
        check({tag, ".preamble_err"}, 32'(preamble_err), 32'(exp_pre));
    endtask

    always @(negedge clk) begin
        if (rst_n && sb.size() > LAT + 1)
            check("rx_stream", 32'({rxd, rx_dv, rx_er}), 32'(sb.pop_front()));
    end

    initial begin
        rst_n = 1'b0; txd = 8'h00; tx_en = 1'b0; tx_er = 1'b0;
        loopback_en = 1'b0; clear_stats = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.rx", 32'({rxd, rx_dv, rx_er}), 32'h0);
        check("tx_clk_fwd", 32'(tx_clk), 32'h1);
        check("rx_clk_fwd", 32'(rx_clk), 32'h1);
        check_stats("reset");
        rst_n = 1'b1;

        lb_en = 1'b1;
        idle(LAT + 2);

        send_frame(7, 8'hD5, 64, -1, -1);   idle(4); check_stats("min_len_good");
        send_frame(7, 8'hD5, 60, -1, -1);   idle(4); check_stats("short");
        send_frame(7, 8'hD5, 1519, -1, -1); idle(4); check_stats("long");
        send_frame(7, 8'hD5, 1518, -1, -1); idle(4); check_stats("max_len_good");

        send_frame(7, 8'hD5, 100, 10, -1);
        tick(GMII_CARRIER_EXT, 1'b0, 1'b1);
        idle(4); check_stats("tx_er");

        send_frame(2, 8'h5D, 20, -1, -1);   idle(4); check_stats("bad_sfd");
        send_frame(1, 8'hD5, 64, -1, -1);   idle(4); check_stats("one_preamble");
        send_frame(8, 8'hD5, 64, -1, -1);   idle(4); check_stats("eight_preamble");

        send_frame(7, 8'hD5, 80, -1, 40);   idle(LAT + 4); check_stats("drop_mid");
        send_frame(7, 8'hD5, 64, -1, -1);   idle(4); check_stats("gated_frame");
        lb_en = 1'b1;
        idle(LAT + 4);

        send_frame(7, 8'hD5, 64, -1, -1);
        clr = 1'b1;
        tick(8'h00, 1'b0, 1'b0);
        clr = 1'b0;
        exp_frames = '0; exp_err = '0; exp_len = '0; exp_pre = 1'b0;
        idle(3); check_stats("clear_wins");

        force dut.u_mon.err_count = 16'hFFFE;
        idle(1);
        release dut.u_mon.err_count;
        exp_err = 16'hFFFE;
        send_frame(7, 8'hD5, 10, -1, -1);   idle(4); check_stats("sat_reach");
        send_frame(7, 8'hD5, 10, -1, -1);   idle(4); check_stats("sat_hold");

        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        exp_frames = '0; exp_err = '0; exp_len = '0; exp_pre = 1'b0;
        idle(LAT + 4); check_stats("clear");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
